// File: rtl/decryption_cfg_pkg.sv
// Shared definitions for the decryption configuration master: command opcodes,
// response status codes, FSM state encoding and the regfile address map.
package decryption_cfg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  typedef enum logic [7:0] {
    ST_OK      = 8'h00,
    ST_REG_ERR = 8'h01,
    ST_TIMEOUT = 8'h02,
    ST_BAD_OP  = 8'hEE
  } status_t;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_ADDR = 4'd1,
    S_GET_DH   = 4'd2,
    S_GET_DL   = 4'd3,
    S_ISSUE    = 4'd4,
    S_WAIT     = 4'd5,
    S_RSP_ST   = 4'd6,
    S_RSP_DH   = 4'd7,
    S_RSP_DL   = 4'd8
  } state_t;

  localparam logic [7:0] REG_SELECT  = 8'h00;
  localparam logic [7:0] REG_CAESAR  = 8'h10;
  localparam logic [7:0] REG_SCYTALE = 8'h12;
  localparam logic [7:0] REG_ZIGZAG  = 8'h14;

  // True for the two opcodes that start a frame with an address byte.
  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/decryption_cfg_master_if.sv
// Bundle of the command stream, response stream and regfile access bus.
// The master modport is the configuration master's view; slave is the
// view of whatever drives commands, consumes responses and serves the regfile.
interface decryption_cfg_master_if #(
  parameter int addr_witdth = 8,
  parameter int reg_width   = 16
);
  logic [7:0]             cmd_data;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [7:0]             rsp_data;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [addr_witdth-1:0] addr;
  logic                   read;
  logic                   write;
  logic [reg_width-1:0]   wdata;
  logic [reg_width-1:0]   rdata;
  logic                   done;
  logic                   error;

  modport master (
    input  cmd_data, cmd_valid, rsp_ready, rdata, done, error,
    output cmd_ready, rsp_data, rsp_valid, addr, read, write, wdata
  );

  modport slave (
    output cmd_data, cmd_valid, rsp_ready, rdata, done, error,
    input  cmd_ready, rsp_data, rsp_valid, addr, read, write, wdata
  );
endinterface

// File: rtl/decryption_cfg_watchdog.sv
// Cycle counter bounding how long the master waits for regfile done.
// load clears the count, count_en advances it, expire flags the last
// allowed cycle so the master can leave WAIT on that same edge.
module decryption_cfg_watchdog #(
  parameter int timeout_cycles = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expire
);

  localparam int CW = $clog2(timeout_cycles + 1);

  logic [CW-1:0] cnt;

  assign expire = count_en && (cnt == CW'(timeout_cycles - 1));

  // Count WAIT cycles, restarting whenever a new access is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count_en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/decryption_cfg_master.sv
// Byte-serial command front end and sole master of the decryption regfile.
// Frames: 01 ADDR DH DL (write), 02 ADDR (read); anything else answers EE.
// Optional feature macro CFG_TIMEOUT_EN: bound the WAIT state with a watchdog
// and answer status 02 when done never arrives.
module decryption_cfg_master
  import decryption_cfg_pkg::*;
#(
  parameter int addr_witdth    = 8,
  parameter int reg_width      = 16,
  parameter int timeout_cycles = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  decryption_cfg_master_if.master bus,
  output logic                    busy
);

  state_t                 state, next_state;
  status_t                status_q;
  logic                   is_read_q;
  logic                   is_write_q;
  logic [addr_witdth-1:0] addr_q;
  logic [reg_width-1:0]   wdata_q;
  logic [reg_width-1:0]   rdata_q;
  logic [7:0]             rsp_data_q;
  logic                   rsp_valid_q;
  logic                   cmd_fire;
  logic                   rsp_fire;
  logic                   wd_expire;

  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign rsp_fire      = rsp_valid_q && bus.rsp_ready;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;

`ifdef CFG_TIMEOUT_EN
  decryption_cfg_watchdog #(
    .timeout_cycles(timeout_cycles)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == S_ISSUE),
    .count_en(state == S_WAIT),
    .expire  (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the handshake, strobe and busy outputs.
  always_comb begin
    next_state    = state;
    bus.cmd_ready = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (cmd_fire) begin
          next_state = is_legal_op(bus.cmd_data) ? S_GET_ADDR : S_RSP_ST;
        end
      end
      S_GET_ADDR: begin
        bus.cmd_ready = 1'b1;
        if (cmd_fire) begin
          next_state = is_write_q ? S_GET_DH : S_ISSUE;
        end
      end
      S_GET_DH: begin
        bus.cmd_ready = 1'b1;
        if (cmd_fire) begin
          next_state = S_GET_DL;
        end
      end
      S_GET_DL: begin
        bus.cmd_ready = 1'b1;
        if (cmd_fire) begin
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.read   = is_read_q;
        bus.write  = is_write_q;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.done || wd_expire) begin
          next_state = S_RSP_ST;
        end
      end
      S_RSP_ST: begin
        if (rsp_fire) begin
          next_state = is_read_q ? S_RSP_DH : S_IDLE;
        end
      end
      S_RSP_DH: begin
        if (rsp_fire) begin
          next_state = S_RSP_DL;
        end
      end
      S_RSP_DL: begin
        if (rsp_fire) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Frame capture, regfile result capture and the registered response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q    <= ST_OK;
      is_read_q   <= 1'b0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            is_read_q  <= (bus.cmd_data == OP_READ);
            is_write_q <= (bus.cmd_data == OP_WRITE);
            if (!is_legal_op(bus.cmd_data)) begin
              status_q <= ST_BAD_OP;
            end
          end
        end
        S_GET_ADDR: begin
          if (cmd_fire) begin
            addr_q <= addr_witdth'(bus.cmd_data);
          end
        end
        S_GET_DH: begin
          if (cmd_fire) begin
            wdata_q[reg_width-1 -: 8] <= bus.cmd_data;
          end
        end
        S_GET_DL: begin
          if (cmd_fire) begin
            wdata_q[7:0] <= bus.cmd_data;
          end
        end
        S_WAIT: begin
          if (bus.done) begin
            status_q <= bus.error ? ST_REG_ERR : ST_OK;
            rdata_q  <= bus.error ? '0 : bus.rdata;
          end else if (wd_expire) begin
            status_q <= ST_TIMEOUT;
            rdata_q  <= '0;
          end
        end
        S_RSP_ST: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= status_q;
          end else if (rsp_fire) begin
            if (is_read_q) begin
              rsp_data_q <= rdata_q[reg_width-1 -: 8];
            end else begin
              rsp_valid_q <= 1'b0;
            end
          end
        end
        S_RSP_DH: begin
          if (rsp_fire) begin
            rsp_data_q <= rdata_q[7:0];
          end
        end
        S_RSP_DL: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
